// File: rtl/iir_biquad_seq.sv
// Direct-form-I biquad sequencer: streams five coefficient/data pairs through an
// external combinational Q15.16 multiplier, accumulates, saturates and emits y[n].
module iir_biquad_seq #(
  parameter int ACC_W  = 36,
  parameter bit SAT_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] sample_i,
  input  logic        sample_valid_i,
  output logic        ready_o,
  input  logic        flush_i,
  input  logic [31:0] b0_i,
  input  logic [31:0] b1_i,
  input  logic [31:0] b2_i,
  input  logic [31:0] a1_i,
  input  logic [31:0] a2_i,
  output logic [31:0] mult_a_o,
  output logic [31:0] mult_b_o,
  input  logic [31:0] mult_c_i,
  output logic [31:0] y_o,
  output logic        y_valid_o,
  output logic [1:0]  dbg_state
);

  // Handshake: a sample transfers on a rising edge where sample_valid_i and ready_o
  // are both high and flush_i is low; valid while ready_o is low is simply ignored.

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [2:0]         tap;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-32:0]  acc_top;
  logic [31:0]        sat_val;
  logic [31:0]        x0, x1, x2, y1, y2;

  assign ready_o   = (state == IDLE);
  assign dbg_state = state;
  assign prod_ext  = {{(ACC_W-32){mult_c_i[31]}}, mult_c_i};
  assign acc_top   = acc[ACC_W-1:31];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_valid_i) state_nxt = MAC;
      MAC:     if (tap == 3'd4) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  // Operand mux: feed-forward taps first, then the two feedback taps.
  always_comb begin
    mult_a_o = 32'd0;
    mult_b_o = 32'd0;
    if (state == MAC) begin
      case (tap)
        3'd0:    begin mult_a_o = b0_i; mult_b_o = x0; end
        3'd1:    begin mult_a_o = b1_i; mult_b_o = x1; end
        3'd2:    begin mult_a_o = b2_i; mult_b_o = x2; end
        3'd3:    begin mult_a_o = a1_i; mult_b_o = y1; end
        3'd4:    begin mult_a_o = a2_i; mult_b_o = y2; end
        default: begin mult_a_o = 32'd0; mult_b_o = 32'd0; end
      endcase
    end
  end

  // In range when every bit above bit 31 matches the sign of bit 31.
  always_comb begin
    sat_val = acc[31:0];
    if (SAT_EN && !((&acc_top) || (~|acc_top)))
      sat_val = acc[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc       <= '0;
      tap       <= 3'd0;
      x0        <= 32'd0;
      x1        <= 32'd0;
      x2        <= 32'd0;
      y1        <= 32'd0;
      y2        <= 32'd0;
      y_o       <= 32'd0;
      y_valid_o <= 1'b0;
    end else if (flush_i) begin
      acc       <= '0;
      tap       <= 3'd0;
      x0        <= 32'd0;
      x1        <= 32'd0;
      x2        <= 32'd0;
      y1        <= 32'd0;
      y2        <= 32'd0;
      y_valid_o <= 1'b0;
    end else begin
      y_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_valid_i) begin
            x0  <= sample_i;
            acc <= '0;
            tap <= 3'd0;
          end
        end
        MAC: begin
          if (tap < 3'd3) acc <= acc + prod_ext;
          else            acc <= acc - prod_ext;
          tap <= tap + 3'd1;
        end
        OUT: begin
          y_o       <= sat_val;
          y_valid_o <= 1'b1;
          x2        <= x1;
          x1        <= x0;
          y2        <= y1;
          y1        <= sat_val;
        end
        default: ;
      endcase
    end
  end

endmodule
